alu_issue_sched: RTL

// - Data-capture issue scheduler feeding NUM_ALU alu instances. Sits between rename/dispatch and the integer ALUs.
// - Buffers dispatched integer micro-ops. Captures source operands from ALU willwrite bypass broadcasts.
// - Each cycle selects the oldest ready entries and drives one registered fuInfo_t per non-stalled ALU.

---
 rtl/alu_issue_sched_pkg.sv | 40 ++++
 rtl/alu_issue_sched_if.sv | 35 +++
 rtl/iq_age_select.sv | 33 +++
 rtl/alu_issue_sched.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_issue_sched_pkg.sv
// rtl/alu_issue_sched_pkg.sv - shared types for the integer ALU issue scheduler
package alu_issue_sched_pkg;

  localparam int XLEN  = 64;
  localparam int IPR_W = 6;

  typedef logic [IPR_W-1:0] iprIdx_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLT = 4'd7
  } micOp_t;

  typedef struct packed {
    micOp_t                micOp;
    logic [5:0]            rob_idx;
    logic [3:0]            irob_idx;
    logic                  rd_wen;
    iprIdx_t               iprd_idx;
    logic [1:0][XLEN-1:0]  srcs;
  } fuInfo_t;

  typedef struct packed {
    logic           valid;
    fuInfo_t        fuInfo;
    iprIdx_t [1:0]  src_idx;
    logic [1:0]     src_rdy;
  } issueEntry_t;

  function automatic logic entry_ready(issueEntry_t e);
    return e.valid & e.src_rdy[0] & e.src_rdy[1];
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// rtl/alu_issue_sched_if.sv - dispatch, wakeup and issue signals of the ALU scheduler
interface alu_issue_sched_if #(
  parameter int DEPTH      = 8,
  parameter int NUM_ALU    = 2,
  parameter int NUM_WAKEUP = 4
);
  import alu_issue_sched_pkg::*;

  logic                                i_squash;
  logic                                i_enq_vld;
  logic                                o_enq_rdy;
  fuInfo_t                             i_enq_info;
  iprIdx_t [1:0]                       i_enq_src_idx;
  logic [1:0]                          i_enq_src_rdy;
  logic [NUM_WAKEUP-1:0]               i_wk_vld;
  iprIdx_t [NUM_WAKEUP-1:0]            i_wk_idx;
  logic [NUM_WAKEUP-1:0][XLEN-1:0]     i_wk_data;
  logic [NUM_ALU-1:0]                  i_fu_stall;
  logic [NUM_ALU-1:0]                  o_issue_vld;
  fuInfo_t [NUM_ALU-1:0]               o_fuInfo;
  logic [$clog2(DEPTH):0]              o_free_cnt;

  modport slave (
    input  i_squash, i_enq_vld, i_enq_info, i_enq_src_idx, i_enq_src_rdy,
           i_wk_vld, i_wk_idx, i_wk_data, i_fu_stall,
    output o_enq_rdy, o_issue_vld, o_fuInfo, o_free_cnt
  );

  modport master (
    output i_squash, i_enq_vld, i_enq_info, i_enq_src_idx, i_enq_src_rdy,
           i_wk_vld, i_wk_idx, i_wk_data, i_fu_stall,
    input  o_enq_rdy, o_issue_vld, o_fuInfo, o_free_cnt
  );

endinterface

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - oldest-first multi-port grant over an age-ordered ready vector
module iq_age_select #(
  parameter int N_ENT  = 8,
  parameter int N_PORT = 2
) (
  input  logic [N_ENT-1:0]              i_ready,
  input  logic [N_PORT-1:0]             i_port_en,
  output logic [N_PORT-1:0][N_ENT-1:0]  o_grant
);

  logic [N_ENT-1:0] w_avail;
  logic             w_found;

  // Ports claim in ascending order; a claimed entry is hidden from later ports.
  always_comb begin
    w_avail = i_ready;
    w_found = 1'b0;
    o_grant = '0;
    for (int k = 0; k < N_PORT; k++) begin
      w_found = 1'b0;
      if (i_port_en[k]) begin
        for (int i = 0; i < N_ENT; i++) begin
          if (!w_found && w_avail[i]) begin
            o_grant[k][i] = 1'b1;
            w_avail[i]    = 1'b0;
            w_found       = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - data-capture collapsing issue queue feeding NUM_ALU integer ALUs
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int NUM_ALU    = 2,
  parameter int NUM_WAKEUP = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_sched_if.slave  io
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  issueEntry_t            r_q [DEPTH];
  logic [CW-1:0]          r_cnt;
  logic [NUM_ALU-1:0]     r_issue_vld;
  fuInfo_t [NUM_ALU-1:0]  r_fu;

  issueEntry_t                   w_wk  [DEPTH];
  issueEntry_t                   w_nxt [DEPTH];
  issueEntry_t                   w_enq_ent;
  issueEntry_t                   w_enq_wk;
  logic [DEPTH-1:0]              w_ready;
  logic [DEPTH-1:0]              w_taken;
  logic [NUM_ALU-1:0][DEPTH-1:0] w_grant;
  logic [NUM_ALU-1:0]            w_gnt_any;
  fuInfo_t [NUM_ALU-1:0]         w_sel_fu;
  logic                          w_enq_rdy;
  logic                          w_enq_fire;
  logic [CW-1:0]                 w_pos;
  logic [CW-1:0]                 w_nxt_cnt;

  function automatic issueEntry_t apply_wakeup(
    issueEntry_t                     e,
    logic [NUM_WAKEUP-1:0]           vld,
    iprIdx_t [NUM_WAKEUP-1:0]        idx,
    logic [NUM_WAKEUP-1:0][XLEN-1:0] data
  );
    issueEntry_t r;
    logic        hit;
    r = e;
    for (int s = 0; s < 2; s++) begin
      hit = 1'b0;
      for (int w = 0; w < NUM_WAKEUP; w++) begin
        if (!hit && !e.src_rdy[s] && vld[w] && (idx[w] == e.src_idx[s])) begin
          r.fuInfo.srcs[s] = data[w];
          r.src_rdy[s]     = 1'b1;
          hit              = 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign w_enq_rdy  = (r_cnt != CW'(DEPTH));
  assign w_enq_fire = io.i_enq_vld & w_enq_rdy & ~io.i_squash;

  always_comb begin
    w_enq_ent         = '0;
    w_enq_ent.valid   = 1'b1;
    w_enq_ent.fuInfo  = io.i_enq_info;
    w_enq_ent.src_idx = io.i_enq_src_idx;
    w_enq_ent.src_rdy = io.i_enq_src_rdy;
    w_enq_wk          = apply_wakeup(w_enq_ent, io.i_wk_vld, io.i_wk_idx, io.i_wk_data);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = entry_ready(r_q[i]);
      w_wk[i]    = apply_wakeup(r_q[i], io.i_wk_vld, io.i_wk_idx, io.i_wk_data);
    end
  end

  iq_age_select #(
    .N_ENT  (DEPTH),
    .N_PORT (NUM_ALU)
  ) u_select (
    .i_ready   (w_ready),
    .i_port_en (~io.i_fu_stall),
    .o_grant   (w_grant)
  );

  // Ports without a grant keep their old payload but never present a write enable.
  always_comb begin
    w_taken = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      w_gnt_any[k]       = |w_grant[k];
      w_taken            = w_taken | w_grant[k];
      w_sel_fu[k]        = r_fu[k];
      w_sel_fu[k].rd_wen = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_grant[k][i]) w_sel_fu[k] = r_q[i].fuInfo;
      end
    end
  end

  // Collapse survivors toward index 0, then append the enqueued op after them.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < DEPTH; i++) w_nxt[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q[i].valid && !w_taken[i]) begin
        w_nxt[w_pos[IW-1:0]] = w_wk[i];
        w_pos                = w_pos + CW'(1);
      end
    end
    if (w_enq_fire) w_nxt[w_pos[IW-1:0]] = w_enq_wk;
    w_nxt_cnt = w_pos + CW'(w_enq_fire);
    if (io.i_squash) begin
      for (int i = 0; i < DEPTH; i++) w_nxt[i] = '0;
      w_nxt_cnt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_nxt;
      r_cnt <= w_nxt_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_vld <= '0;
      r_fu        <= '0;
    end else begin
      for (int k = 0; k < NUM_ALU; k++) begin
        if (io.i_squash) begin
          r_issue_vld[k]  <= 1'b0;
          r_fu[k].rd_wen  <= 1'b0;
        end else if (!io.i_fu_stall[k]) begin
          r_issue_vld[k]  <= w_gnt_any[k];
          r_fu[k]         <= w_sel_fu[k];
        end
      end
    end
  end

  assign io.o_enq_rdy   = w_enq_rdy;
  assign io.o_free_cnt  = CW'(DEPTH) - r_cnt;
  assign io.o_issue_vld = r_issue_vld;
  assign io.o_fuInfo    = r_fu;

endmodule
